// File: rtl/param_step_decrementer.sv
//==============================================================================
// Module      : param_step_decrementer
// Description : Registered, loadable down-counter that subtracts a programmable
//               step per enabled cycle, with wrap/saturate underflow handling,
//               auto-reload, and terminal-count/borrow pulses.
//               Optional up/down support: define PARAM_DECR_UPDOWN_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module param_step_decrementer #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef PARAM_DECR_UPDOWN_EN
   input  logic              dir,
`endif
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              en,
   input  logic [STEP_W-1:0] step,
   input  logic              mode_sat,
   input  logic              auto_reload,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              zero,
   output logic              tc_pulse,
   output logic              borrow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] c_zero = '0;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_count, w_count_nxt;
   logic [WIDTH-1:0] r_reload, w_reload_nxt;
   logic             r_zero, r_tc, r_borrow;
   logic             w_tc_nxt, w_borrow_nxt;
   logic [WIDTH-1:0] w_step;

   assign w_step = WIDTH'(step);

`ifdef PARAM_DECR_UPDOWN_EN
   localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
   logic [WIDTH:0] w_sum;
   // Extra MSB exposes the carry out of the up-count.
   assign w_sum = {1'b0, r_count} + {1'b0, w_step};
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;
      w_borrow_nxt = 1'b0;

      if (load) begin
         w_count_nxt  = load_val;
         w_reload_nxt = load_val;
         w_state_nxt  = (load_val != c_zero) ? ST_RUN : ST_DONE;
      end else if (r_state == ST_RUN && en && w_step != c_zero) begin
`ifdef PARAM_DECR_UPDOWN_EN
         if (dir) begin
            if (!w_sum[WIDTH]) begin
               w_count_nxt = w_sum[WIDTH-1:0];
            end else if (mode_sat) begin
               w_count_nxt = c_max;
               w_tc_nxt    = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_count_nxt  = w_sum[WIDTH-1:0];
               w_borrow_nxt = 1'b1;
            end
         end else
`endif
         if (r_count > w_step) begin
            w_count_nxt = r_count - w_step;
         end else if (r_count == w_step || mode_sat) begin
            // Exact hit and saturating underflow share the terminal path.
            w_tc_nxt = 1'b1;
            if (auto_reload && r_reload != c_zero) begin
               w_count_nxt = r_reload;
            end else begin
               w_count_nxt = c_zero;
               w_state_nxt = ST_DONE;
            end
         end else begin
            w_count_nxt  = r_count - w_step;
            w_borrow_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_zero   <= 1'b1;
         r_tc     <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_zero   <= (w_count_nxt == c_zero);
         r_tc     <= w_tc_nxt;
         r_borrow <= w_borrow_nxt;
      end
   end

   assign count    = r_count;
   assign busy     = (r_state == ST_RUN);
   assign zero     = r_zero;
   assign tc_pulse = r_tc;
   assign borrow   = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_param_step_decrementer.sv
//==============================================================================
// Module      : tb_param_step_decrementer
// Description : Self-checking bench: directed scenarios plus randomized traffic
//               against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_param_step_decrementer;

   localparam int W    = 8;
   localparam int SW   = 4;
   localparam int MODV = 1 << W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load, en, mode_sat, auto_reload;
   logic [W-1:0]  load_val;
   logic [SW-1:0] step;
   logic [W-1:0]  count;
   logic          busy, zero, tc_pulse, borrow;

   int errors = 0;
   int checks = 0;

   // Behavioural model: 0 = idle, 1 = running, 2 = done
   int m_state, m_count, m_reload;
   bit m_tc, m_borrow;

   always #5 clk = ~clk;

   param_step_decrementer #(.WIDTH(W), .STEP_W(SW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef PARAM_DECR_UPDOWN_EN
      .dir         (1'b0),
`endif
      .load        (load),
      .load_val    (load_val),
      .en          (en),
      .step        (step),
      .mode_sat    (mode_sat),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .zero        (zero),
      .tc_pulse    (tc_pulse),
      .borrow      (borrow)
   );

   task automatic model_reset();
      m_state = 0; m_count = 0; m_reload = 0; m_tc = 0; m_borrow = 0;
   endtask

   // Advance one clock edge, update the model with the inputs seen at that edge.
   task automatic tick();
      int d;
      @(posedge clk);
      m_tc = 0; m_borrow = 0;
      if (load) begin
         m_count  = int'(load_val);
         m_reload = int'(load_val);
         m_state  = (load_val != 0) ? 1 : 2;
      end else if (m_state == 1 && en && step != 0) begin
         d = m_count - int'(step);
         if (d > 0) m_count = d;
         else if (d == 0 || mode_sat) begin
            m_tc = 1;
            if (auto_reload && m_reload != 0) m_count = m_reload;
            else begin m_count = 0; m_state = 2; end
         end else begin
            m_count = d + MODV; m_borrow = 1;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      load = 0; load_val = '0; en = 0; step = '0; mode_sat = 0; auto_reload = 0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load = 1; load_val = v; tick(); load = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; idle_inputs(); model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (count !== 8'd0 || busy !== 1'b0 || zero !== 1'b1 || tc_pulse !== 1'b0 || borrow !== 1'b0) begin
         errors++; $display("FAIL reset_state: count=%0d busy=%b zero=%b tc=%b borrow=%b, want 0 0 1 0 0", count, busy, zero, tc_pulse, borrow);
      end
      rst_n = 1; en = 1; step = 4'd3; tick();
      checks++; if (count !== 8'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_ignores_en: count=%0d busy=%b, want 0 0", count, busy);
      end
      do_load(8'd50); en = 1; step = 4'd1;
      repeat (3) tick();
      checks++; if (count !== 8'd47 || busy !== 1'b1) begin
         errors++; $display("FAIL reset_pre_run: count=%0d busy=%b, want 47 1", count, busy);
      end
      #2 rst_n = 0;
      #1;
      checks++; if (count !== 8'd0 || busy !== 1'b0 || zero !== 1'b1) begin
         errors++; $display("FAIL async_reset: count=%0d busy=%b zero=%b, want 0 0 1", count, busy, zero);
      end
      idle_inputs(); model_reset();
      #1 rst_n = 1;
   endtask

   task automatic test_exact_terminal();
      logic [W-1:0] exp_seq[3] = '{8'd8, 8'd4, 8'd0};
      idle_inputs(); do_load(8'd12);
      en = 1; step = 4'd4;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (count !== exp_seq[i] || tc_pulse !== (i == 2) || busy !== (i != 2)) begin
            errors++; $display("FAIL exact_step%0d: count=%0d tc=%b busy=%b, want %0d %b %b", i, count, tc_pulse, busy, exp_seq[i], (i == 2), (i != 2));
         end
      end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL exact_zero: zero=%b, want 1", zero); end
      tick();
      checks++; if (count !== 8'd0 || tc_pulse !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL done_ignores_en: count=%0d tc=%b busy=%b, want 0 0 0", count, tc_pulse, busy);
      end
   endtask

   task automatic test_wrap();
      idle_inputs(); do_load(8'd5);
      en = 1; step = 4'd7; mode_sat = 0; tick();
      checks++; if (count !== 8'd254 || borrow !== 1'b1 || tc_pulse !== 1'b0 || busy !== 1'b1 || zero !== 1'b0) begin
         errors++; $display("FAIL wrap: count=%0d borrow=%b tc=%b busy=%b zero=%b, want 254 1 0 1 0", count, borrow, tc_pulse, busy, zero);
      end
      en = 0; tick();
      checks++; if (count !== 8'd254 || borrow !== 1'b0) begin
         errors++; $display("FAIL wrap_hold: count=%0d borrow=%b, want 254 0", count, borrow);
      end
   endtask

   task automatic test_saturate();
      idle_inputs(); do_load(8'd5);
      en = 1; step = 4'd7; mode_sat = 1; tick();
      checks++; if (count !== 8'd0 || tc_pulse !== 1'b1 || borrow !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
         errors++; $display("FAIL saturate: count=%0d tc=%b borrow=%b busy=%b zero=%b, want 0 1 0 0 1", count, tc_pulse, borrow, busy, zero);
      end
   endtask

   task automatic test_auto_reload();
      logic [W-1:0] exp_seq[6] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
      idle_inputs(); do_load(8'd3);
      en = 1; step = 4'd1; auto_reload = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (count !== exp_seq[i] || tc_pulse !== (exp_seq[i] == 8'd3) || zero !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL reload_step%0d: count=%0d tc=%b zero=%b busy=%b, want %0d %b 0 1", i, count, tc_pulse, zero, busy, exp_seq[i], (exp_seq[i] == 8'd3));
         end
      end
   endtask

   task automatic test_load_priority();
      idle_inputs(); do_load(8'd50);
      en = 1; step = 4'd2; tick();
      en = 0; tick(); tick();
      checks++; if (count !== 8'd48 || tc_pulse !== 1'b0 || borrow !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL en_low_hold: count=%0d tc=%b borrow=%b busy=%b, want 48 0 0 1", count, tc_pulse, borrow, busy);
      end
      en = 1; step = 4'd0; tick();
      checks++; if (count !== 8'd48 || tc_pulse !== 1'b0) begin
         errors++; $display("FAIL step_zero: count=%0d tc=%b, want 48 0", count, tc_pulse);
      end
      step = 4'd1; load = 1; load_val = 8'd0; tick(); load = 0;
      checks++; if (count !== 8'd0 || busy !== 1'b0 || tc_pulse !== 1'b0 || zero !== 1'b1) begin
         errors++; $display("FAIL load_priority: count=%0d busy=%b tc=%b zero=%b, want 0 0 0 1", count, busy, tc_pulse, zero);
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         load        = ($urandom_range(0, 11) == 0);
         load_val    = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
         en          = ($urandom_range(0, 3) != 0);
         step        = SW'($urandom);
         mode_sat    = ($urandom_range(0, 2) == 0);
         auto_reload = ($urandom_range(0, 2) == 0);
         tick();
         checks++; if (int'(count) !== m_count || busy !== (m_state == 1) || zero !== (m_count == 0) || tc_pulse !== m_tc || borrow !== m_borrow) begin
            errors++; $display("FAIL random_%0d: count=%0d busy=%b zero=%b tc=%b borrow=%b, want %0d %b %b %b %b", i, count, busy, zero, tc_pulse, borrow, m_count, (m_state == 1), (m_count == 0), m_tc, m_borrow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exact_terminal();
      test_wrap();
      test_saturate();
      test_auto_reload();
      test_load_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
